lsu_mmio: RTL and testbench
===========================

Name: lsu_mmio

Overview:
- Parametrised load-store unit for the RV32I core.
- Decodes the address into byte-addressable data memory, output peripheral registers (LEDR, LEDG, HEX0-7, LCD) and synchronised inputs (SW, BTN).
- Generates byte strobes internally from access size; sign/zero-extends loads.
- Returns load data with fixed 1-cycle latency; sits between the EX stage address/data and the writeback mux.

Parameters:
- DMEM_WORDS, 2048, data memory depth in 32-bit words (power of two, 8 KiB default).
- DMEM_BASE, 32'h0000_2000, byte base address of data memory.
- IO_OUT_BASE, 32'h0000_7000, base of the 64-byte output peripheral window.
- IO_IN_BASE, 32'h0000_7800, base of the 32-byte input window.
- SYNC_STAGES, 2, flop stages on i_io_sw/i_io_btn (must be ≥2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_req  in  1  access valid this cycle
- i_we  in  1  1=store, 0=load (qualified by i_req)
- i_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  byte address
- i_st_data  in  32  store data, right-aligned
- o_ld_valid  out  1  load data valid (1 cycle after load request)
- o_ld_data  out  32  extended load data
- o_misaligned  out  1  registered pulse: misaligned access rejected
- o_addr_err  out  1  registered pulse: access to unmapped address
- o_io_ledr  out  32  LEDR register
- o_io_ledg  out  32  LEDG register
- o_io_hex0..o_io_hex7  out  7 each  seven-segment registers
- o_io_lcd  out  32  LCD register
- i_io_sw  in  32  switches, asynchronous
- i_io_btn  in  4  buttons, asynchronous

Behaviour:
- Clock/reset (already decided): one clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values:
  - All IO output registers, o_ld_valid, o_ld_data, o_misaligned, o_addr_err and sync flops = 0.
  - DMEM contents are not reset.
- Map (offsets from window base):
  - DMEM: [DMEM_BASE, DMEM_BASE+4*DMEM_WORDS).
  - OUT window: +0x00 LEDR, +0x10 LEDG, +0x20 HEX0-3, +0x24 HEX4-7, +0x30 LCD.
    - HEX packing: HEXn occupies bits [8k+6:8k], k = n mod 4; bit 8k+7 is read as 0.
  - IN window: +0x00 SW, +0x10 BTN (bits [3:0], upper bits read 0).
  - Any other address is unmapped.
- Alignment:
  - H requires addr[0]=0; W requires addr[1:0]=0.
  - A violation blocks the write; a violating load returns 0.
  - o_misaligned pulses next cycle; o_addr_err is not raised.
- Stores:
  - Strobe = 0001/0011/1111 shifted left by addr[1:0].
  - Data replicated across byte lanes (B: x4, H: x2).
  - Write commits at the rising edge of the request cycle.
  - Stores to DMEM and OUT registers are byte-masked.
  - Stores to the IN window or unmapped addresses are ignored; o_addr_err pulses for unmapped only.
- Loads:
  - Source word is read synchronously at the request edge; o_ld_valid=1 and o_ld_data are presented the next cycle.
  - Lane selected by the registered addr[1:0]; sign-extend for B/H, zero-extend for BU/HU.
  - Unmapped load returns 0 and raises o_addr_err.
  - funct3 011/110/111 is treated as W.
- Back-to-back:
  - One access per cycle, no stall.
  - A store followed by a load to the same address next cycle returns the new data.
- SW/BTN pass through SYNC_STAGES flops; a load sees the value from the last flop.
- Error pulses and o_ld_valid last exactly one cycle and are 0 when i_req=0.
- Reset asserted mid-load: o_ld_valid is forced low asynchronously; the pending load is discarded.
- DMEM index = (addr-DMEM_BASE)[log2(DMEM_WORDS)+1:2]; no wrap beyond depth (out of range = unmapped).

Decomposition:
- rv32i_pkg gains:
  - lsu_funct3_e enum.
  - Address-map localparams (offsets).
  - Region enum {REG_DMEM, REG_OUT, REG_IN, REG_NONE}.
  - A function returning strobe from size and addr[1:0].
- One sub-module, lsu_dmem: byte-enable synchronous RAM (DMEM_WORDS x 32, 4 strobes, registered read), inferable as block RAM.

Test Plan:
- Reset then idle: all IO outputs 0, o_ld_valid 0, with i_rst asserted mid-cycle asynchronously.
- SW at 0x2000 of 0xDEADBEEF, then LB at 0x2003 → 0xFFFFFFDE, LBU → 0x000000DE, LH at 0x2002 → 0xFFFFDEAD, LW → 0xDEADBEEF, each valid one cycle after request.
- SB 0xA5 to 0x7021 → o_io_hex1=7'h25, other HEX unchanged; LW at 0x7020 → 0x00002500.
- Drive i_io_sw=0x12345678: LW at 0x7800 returns old value until SYNC_STAGES edges pass, then 0x12345678; SW to 0x7800 ignored, no error.
- SH to 0x2001 → o_misaligned pulse, memory unchanged; LW at 0x5000 → 0 with o_addr_err pulse.
- Back-to-back SW 0x11223344 to 0x2010 then LW 0x2010 → 0x11223344 on the following cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings, the MMIO address map
// and the byte-strobe helper used by the load-store unit.
package rv32i_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_e;

    typedef enum logic [1:0] {
        REG_DMEM,
        REG_OUT,
        REG_IN,
        REG_NONE
    } region_e;

    // Byte offsets inside the output (64-byte) and input (32-byte) windows
    localparam logic [5:0] OUT_LEDR_OFF  = 6'h00;
    localparam logic [5:0] OUT_LEDG_OFF  = 6'h10;
    localparam logic [5:0] OUT_HEXLO_OFF = 6'h20;
    localparam logic [5:0] OUT_HEXHI_OFF = 6'h24;
    localparam logic [5:0] OUT_LCD_OFF   = 6'h30;
    localparam logic [4:0] IN_SW_OFF     = 5'h00;
    localparam logic [4:0] IN_BTN_OFF    = 5'h10;

    // Reserved encodings 011/110/111 fall into the word case
    function automatic lsu_size_e lsu_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: lsu_size = SZ_B;
            F3_H, F3_HU: lsu_size = SZ_H;
            default:     lsu_size = SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] lsu_strobe(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    lsu_strobe = 4'b0001 << off;
            SZ_H:    lsu_strobe = 4'b0011 << off;
            default: lsu_strobe = 4'b1111 << off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-enable synchronous data RAM with registered read; written so that
// synthesis maps it onto block RAM.
module lsu_dmem #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    strb,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && strb[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lsu_mmio.sv
// RV32I load-store unit: decodes DMEM / output registers / synchronised inputs,
// byte-masks stores and returns extended load data one cycle after the request.
module lsu_mmio
    import rv32i_pkg::*;
#(
    parameter int          DMEM_WORDS  = 2048,
    parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
    parameter logic [31:0] IO_OUT_BASE = 32'h0000_7000,
    parameter logic [31:0] IO_IN_BASE  = 32'h0000_7800,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_ld_valid,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic        o_addr_err,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn
);

    localparam int AW = $clog2(DMEM_WORDS);

    // Decode works on word addresses so that every address bit takes part
    logic [29:0] dmem_woff, out_woff, in_woff;
    lsu_size_e   size;
    logic        misaligned;
    region_e     region;
    logic [31:0] io_rd_word;
    logic [31:0] st_word;
    logic [3:0]  strb;
    logic        st_ok;

    logic [31:0] sw_sync  [SYNC_STAGES];
    logic [3:0]  btn_sync [SYNC_STAGES];
    logic [6:0]  hex_q    [8];

    logic        ld_valid_q, ld_zero_q, ld_from_mem_q, ld_unsigned_q;
    lsu_size_e   ld_size_q;
    logic [1:0]  ld_lane_q;
    logic [31:0] ld_io_q;
    logic [31:0] mem_rdata;
    logic [31:0] ld_word, lane_data, ld_ext;

    assign dmem_woff = i_addr[31:2] - DMEM_BASE[31:2];
    assign out_woff  = i_addr[31:2] - IO_OUT_BASE[31:2];
    assign in_woff   = i_addr[31:2] - IO_IN_BASE[31:2];

    always_comb begin
        size       = lsu_size(i_funct3);
        misaligned = ((size == SZ_H) && i_addr[0]) ||
                     ((size == SZ_W) && (i_addr[1:0] != 2'b00));
        region     = REG_NONE;
        io_rd_word = '0;
        if (dmem_woff < 30'(DMEM_WORDS)) begin
            region = REG_DMEM;
        end else if (out_woff[29:4] == '0) begin
            region = REG_OUT;
            case (out_woff[3:0])
                OUT_LEDR_OFF[5:2]:  io_rd_word = o_io_ledr;
                OUT_LEDG_OFF[5:2]:  io_rd_word = o_io_ledg;
                OUT_HEXLO_OFF[5:2]: io_rd_word = {1'b0, hex_q[3], 1'b0, hex_q[2],
                                                  1'b0, hex_q[1], 1'b0, hex_q[0]};
                OUT_HEXHI_OFF[5:2]: io_rd_word = {1'b0, hex_q[7], 1'b0, hex_q[6],
                                                  1'b0, hex_q[5], 1'b0, hex_q[4]};
                OUT_LCD_OFF[5:2]:   io_rd_word = o_io_lcd;
                default:            region = REG_NONE;
            endcase
        end else if (in_woff[29:3] == '0) begin
            region = REG_IN;
            case (in_woff[2:0])
                IN_SW_OFF[4:2]:  io_rd_word = sw_sync[SYNC_STAGES-1];
                IN_BTN_OFF[4:2]: io_rd_word = {28'b0, btn_sync[SYNC_STAGES-1]};
                default:         region = REG_NONE;
            endcase
        end
    end

    always_comb begin
        strb = lsu_strobe(size, i_addr[1:0]);
        case (size)
            SZ_B:    st_word = {4{i_st_data[7:0]}};
            SZ_H:    st_word = {2{i_st_data[15:0]}};
            default: st_word = i_st_data;
        endcase
        st_ok = i_req && i_we && !misaligned;
    end

    lsu_dmem #(.DEPTH(DMEM_WORDS)) u_dmem (
        .clk   (i_clk),
        .we    (st_ok && (region == REG_DMEM)),
        .strb  (strb),
        .addr  (dmem_woff[AW-1:0]),
        .wdata (st_word),
        .rdata (mem_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_sync[s]  <= '0;
                btn_sync[s] <= '0;
            end
        end else begin
            sw_sync[0]  <= i_io_sw;
            btn_sync[0] <= i_io_btn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_sync[s]  <= sw_sync[s-1];
                btn_sync[s] <= btn_sync[s-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_io_ledr <= '0;
            o_io_ledg <= '0;
            o_io_lcd  <= '0;
            for (int n = 0; n < 8; n++) hex_q[n] <= '0;
        end else if (st_ok && (region == REG_OUT)) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) begin
                    case (out_woff[3:0])
                        OUT_LEDR_OFF[5:2]:  o_io_ledr[8*k +: 8] <= st_word[8*k +: 8];
                        OUT_LEDG_OFF[5:2]:  o_io_ledg[8*k +: 8] <= st_word[8*k +: 8];
                        OUT_HEXLO_OFF[5:2]: hex_q[k]            <= st_word[8*k +: 7];
                        OUT_HEXHI_OFF[5:2]: hex_q[k+4]          <= st_word[8*k +: 7];
                        OUT_LCD_OFF[5:2]:   o_io_lcd[8*k +: 8]  <= st_word[8*k +: 8];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ld_valid_q    <= 1'b0;
            ld_zero_q     <= 1'b0;
            ld_from_mem_q <= 1'b0;
            ld_unsigned_q <= 1'b0;
            ld_size_q     <= SZ_W;
            ld_lane_q     <= '0;
            ld_io_q       <= '0;
            o_misaligned  <= 1'b0;
            o_addr_err    <= 1'b0;
        end else begin
            ld_valid_q    <= i_req && !i_we;
            ld_zero_q     <= misaligned || (region == REG_NONE);
            ld_from_mem_q <= (region == REG_DMEM);
            ld_unsigned_q <= i_funct3[2];
            ld_size_q     <= size;
            ld_lane_q     <= i_addr[1:0];
            ld_io_q       <= io_rd_word;
            o_misaligned  <= i_req && misaligned;
            o_addr_err    <= i_req && !misaligned && (region == REG_NONE);
        end
    end

    // Words are aligned when they get here, so the shifted word is the word itself
    always_comb begin
        ld_word   = ld_from_mem_q ? mem_rdata : ld_io_q;
        lane_data = ld_word >> {ld_lane_q, 3'b000};
        case (ld_size_q)
            SZ_B:    ld_ext = ld_unsigned_q ? {24'b0, lane_data[7:0]}
                                            : {{24{lane_data[7]}}, lane_data[7:0]};
            SZ_H:    ld_ext = ld_unsigned_q ? {16'b0, lane_data[15:0]}
                                            : {{16{lane_data[15]}}, lane_data[15:0]};
            default: ld_ext = lane_data;
        endcase
    end

    assign o_ld_valid = ld_valid_q;
    assign o_ld_data  = (ld_valid_q && !ld_zero_q) ? ld_ext : '0;

    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio: stores, extended loads, HEX packing, input
// synchronisers, alignment/unmapped errors and asynchronous reset mid-load.
module tb_lsu_mmio;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] st_data = '0;
    logic [31:0] io_sw = '0;
    logic [3:0]  io_btn = '0;
    logic        ld_valid, misaligned, addr_err;
    logic [31:0] ld_data, io_ledr, io_ledg, io_lcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    always #5 clk = ~clk;

    lsu_mmio dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_we         (we),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_st_data    (st_data),
        .o_ld_valid   (ld_valid),
        .o_ld_data    (ld_data),
        .o_misaligned (misaligned),
        .o_addr_err   (addr_err),
        .o_io_ledr    (io_ledr),
        .o_io_ledg    (io_ledg),
        .o_io_hex0    (hex0),
        .o_io_hex1    (hex1),
        .o_io_hex2    (hex2),
        .o_io_hex3    (hex3),
        .o_io_hex4    (hex4),
        .o_io_hex5    (hex5),
        .o_io_hex6    (hex6),
        .o_io_hex7    (hex7),
        .o_io_lcd     (io_lcd),
        .i_io_sw      (io_sw),
        .i_io_btn     (io_btn)
    );

    // Drive one request on the falling edge; return 1 ns after the edge that takes it
    task automatic applyStimulus(input logic r, input logic w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = r; we = w; funct3 = f3; addr = a; st_data = d;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset asserted mid-cycle before any clock edge
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_ledr", io_ledr, 32'h0);
        checkOutput("rst_ledg", io_ledg, 32'h0);
        checkOutput("rst_lcd", io_lcd, 32'h0);
        checkOutput("rst_hex03", {4'h0, hex3, hex2, hex1, hex0}, 32'h0);
        checkOutput("rst_hex47", {4'h0, hex7, hex6, hex5, hex4}, 32'h0);
        checkOutput("rst_ld_valid", {31'b0, ld_valid}, 32'h0);
        checkOutput("rst_ld_data", ld_data, 32'h0);
        checkOutput("rst_err", {30'b0, misaligned, addr_err}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, W, 32'h0, 32'h0);
        checkOutput("idle_ld_valid", {31'b0, ld_valid}, 32'h0);

        // DMEM word store then extended loads
        applyStimulus(1, 1, W, 32'h2000, 32'hDEADBEEF);
        checkOutput("sw_no_valid", {29'b0, ld_valid, misaligned, addr_err}, 32'h0);
        applyStimulus(1, 0, B, 32'h2003, 32'h0);
        checkOutput("lb_valid", {31'b0, ld_valid}, 32'h1);
        checkOutput("lb_data", ld_data, 32'hFFFFFFDE);
        applyStimulus(1, 0, BU, 32'h2003, 32'h0);
        checkOutput("lbu_data", ld_data, 32'h000000DE);
        applyStimulus(1, 0, H, 32'h2002, 32'h0);
        checkOutput("lh_data", ld_data, 32'hFFFFDEAD);
        applyStimulus(1, 0, HU, 32'h2000, 32'h0);
        checkOutput("lhu_data", ld_data, 32'h0000BEEF);
        applyStimulus(1, 0, W, 32'h2000, 32'h0);
        checkOutput("lw_data", ld_data, 32'hDEADBEEF);
        applyStimulus(0, 0, W, 32'h0, 32'h0);
        checkOutput("valid_one_cycle", {31'b0, ld_valid}, 32'h0);
        checkOutput("idle_ld_data", ld_data, 32'h0);

        // Output registers and HEX packing
        applyStimulus(1, 1, B, 32'h7021, 32'h000000A5);
        checkOutput("hex1", {25'b0, hex1}, 32'h25);
        checkOutput("hex_others", {4'h0, hex7, hex6, hex5, hex4, hex3, hex2, hex0}, 32'h0);
        applyStimulus(1, 0, W, 32'h7020, 32'h0);
        checkOutput("lw_hexlo", ld_data, 32'h00002500);
        applyStimulus(1, 1, B, 32'h7024, 32'h0000003C);
        checkOutput("hex4", {25'b0, hex4}, 32'h3C);
        applyStimulus(1, 0, W, 32'h7024, 32'h0);
        checkOutput("lw_hexhi", ld_data, 32'h0000003C);
        applyStimulus(1, 1, W, 32'h7000, 32'hCAFEF00D);
        checkOutput("ledr", io_ledr, 32'hCAFEF00D);
        applyStimulus(1, 1, H, 32'h7032, 32'h0000BEEF);
        checkOutput("lcd", io_lcd, 32'hBEEF0000);
        checkOutput("ledg_untouched", io_ledg, 32'h0);
        applyStimulus(1, 0, HU, 32'h7032, 32'h0);
        checkOutput("lhu_lcd", ld_data, 32'h0000BEEF);

        // Switch synchroniser latency
        io_sw = 32'h12345678;
        applyStimulus(1, 0, W, 32'h7800, 32'h0);
        checkOutput("sw_sync_e1", ld_data, 32'h0);
        applyStimulus(1, 0, W, 32'h7800, 32'h0);
        checkOutput("sw_sync_e2", ld_data, 32'h0);
        applyStimulus(1, 0, W, 32'h7800, 32'h0);
        checkOutput("sw_sync_e3", ld_data, 32'h12345678);
        applyStimulus(1, 1, W, 32'h7800, 32'hFFFFFFFF);
        checkOutput("st_in_no_err", {30'b0, misaligned, addr_err}, 32'h0);
        applyStimulus(1, 0, W, 32'h7800, 32'h0);
        checkOutput("sw_after_st", ld_data, 32'h12345678);
        io_btn = 4'hA;
        applyStimulus(0, 0, W, 32'h0, 32'h0);
        applyStimulus(0, 0, W, 32'h0, 32'h0);
        applyStimulus(1, 0, W, 32'h7810, 32'h0);
        checkOutput("btn", ld_data, 32'h0000000A);

        // Alignment and unmapped errors
        applyStimulus(1, 1, H, 32'h2001, 32'h00001234);
        checkOutput("sh_misaligned", {30'b0, misaligned, addr_err}, 32'h2);
        applyStimulus(0, 0, W, 32'h0, 32'h0);
        checkOutput("misaligned_pulse", {30'b0, misaligned, addr_err}, 32'h0);
        applyStimulus(1, 0, W, 32'h2000, 32'h0);
        checkOutput("mem_unchanged", ld_data, 32'hDEADBEEF);
        applyStimulus(1, 0, W, 32'h2002, 32'h0);
        checkOutput("lw_misaligned", {ld_data[29:0], misaligned, ld_valid}, 32'h3);
        applyStimulus(1, 0, W, 32'h5000, 32'h0);
        checkOutput("unmapped_data", ld_data, 32'h0);
        checkOutput("unmapped_err", {29'b0, ld_valid, misaligned, addr_err}, 32'h5);
        applyStimulus(1, 0, W, 32'h4000, 32'h0);
        checkOutput("past_dmem_err", {30'b0, misaligned, addr_err}, 32'h1);
        applyStimulus(1, 0, W, 32'h703C, 32'h0);
        checkOutput("out_hole_err", {30'b0, misaligned, addr_err}, 32'h1);
        applyStimulus(1, 1, W, 32'h5000, 32'h1);
        checkOutput("st_unmapped_err", {30'b0, misaligned, addr_err}, 32'h1);

        // Back-to-back store/load and the last DMEM word
        applyStimulus(1, 1, W, 32'h2010, 32'h11223344);
        applyStimulus(1, 0, W, 32'h2010, 32'h0);
        checkOutput("b2b_lw", ld_data, 32'h11223344);
        applyStimulus(1, 1, W, 32'h3FFC, 32'h55AA00FF);
        applyStimulus(1, 0, B, 32'h3FFC, 32'h0);
        checkOutput("top_lb0", ld_data, 32'hFFFFFFFF);
        applyStimulus(1, 0, B, 32'h3FFD, 32'h0);
        checkOutput("top_lb1", ld_data, 32'h0);
        applyStimulus(1, 0, H, 32'h3FFE, 32'h0);
        checkOutput("top_lh", ld_data, 32'h000055AA);

        // Asynchronous reset while a load result is being presented
        applyStimulus(1, 0, W, 32'h2000, 32'h0);
        checkOutput("pre_rst_valid", {31'b0, ld_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_valid", {31'b0, ld_valid}, 32'h0);
        checkOutput("midrst_data", ld_data, 32'h0);
        checkOutput("midrst_ledr", io_ledr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, W, 32'h0, 32'h0);
        checkOutput("post_rst_valid", {31'b0, ld_valid}, 32'h0);
        applyStimulus(1, 0, W, 32'h2000, 32'h0);
        checkOutput("dmem_kept", ld_data, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
